nes_pad_reader: RTL

- Serial front end for the game controller; produces the parallel `controller_data[7:0]` bus and the `cnt_int` interrupt that the MIPS core consumes.
- Drives the pad's latch and pulse lines and shifts in 8 button bits (active-low on the wire).
- Presents a registered, inverted (1 = pressed) button byte.
- Raises a sticky interrupt whenever the byte changes.

---
 rtl/nes_pad_reader.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/nes_pad_reader.sv
// Serial reader for the NES game pad: latches and clocks the pad, presents the
// button byte (1 = pressed) with a sticky change interrupt. Define DEBOUNCE_EN to
// require two identical consecutive polls before the byte updates.
//
// state    | meaning
// ---------+--------------------------------------------------
// IDLE     | counting idle cycles between polls while en==1
// LATCH    | pad_latch high for 2*CLK_DIV cycles
// SAMPLE   | capture one serial bit (inverted) into shift
// PULSE_HI | pad_pulse high for CLK_DIV cycles
// PULSE_LO | pad_pulse low for CLK_DIV cycles, advance bit
// DONE     | publish byte, pulse data_valid, update cnt_int
module nes_pad_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       pad_data,
    input  logic       int_ack,
    output logic       pad_latch,
    output logic       pad_pulse,
    output logic [7:0] controller_data,
    output logic       data_valid,
    output logic       cnt_int
);

    localparam int TW = $clog2(2 * CLK_DIV + 1);
    localparam int CW = $clog2(POLL_PERIOD + 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        SAMPLE,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    state_t       state, state_n;
    logic [CW-1:0] idle_cnt, idle_cnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]   bit_idx, bit_idx_n;
    logic [7:0]   shift, shift_n;
    logic [7:0]   data_n;
    logic         valid_n;
    logic         int_n;
    logic         latch_n;
    logic         pulse_n;
`ifdef DEBOUNCE_EN
    logic [7:0]   prev_raw, prev_n;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            idle_cnt        <= '0;
            timer           <= '0;
            bit_idx         <= '0;
            shift           <= '0;
            controller_data <= '0;
            data_valid      <= 1'b0;
            cnt_int         <= 1'b0;
            pad_latch       <= 1'b0;
            pad_pulse       <= 1'b0;
`ifdef DEBOUNCE_EN
            prev_raw        <= '0;
`endif
        end else begin
            state           <= state_n;
            idle_cnt        <= idle_cnt_n;
            timer           <= timer_n;
            bit_idx         <= bit_idx_n;
            shift           <= shift_n;
            controller_data <= data_n;
            data_valid      <= valid_n;
            cnt_int         <= int_n;
            pad_latch       <= latch_n;
            pad_pulse       <= pulse_n;
`ifdef DEBOUNCE_EN
            prev_raw        <= prev_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        idle_cnt_n = idle_cnt;
        timer_n    = timer;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        data_n     = controller_data;
        valid_n    = 1'b0;
        int_n      = cnt_int & ~int_ack;
`ifdef DEBOUNCE_EN
        prev_n     = prev_raw;
`endif

        case (state)
            IDLE: begin
                if (!en) begin
                    idle_cnt_n = '0;
                end else if (idle_cnt == CW'(POLL_PERIOD - 1)) begin
                    state_n    = LATCH;
                    idle_cnt_n = '0;
                    timer_n    = TW'(2 * CLK_DIV - 1);
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (timer == '0) begin
                    state_n   = SAMPLE;
                    bit_idx_n = '0;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            SAMPLE: begin
                shift_n[bit_idx] = ~pad_data;
                if (bit_idx == 3'd7) begin
                    state_n = DONE;
                end else begin
                    state_n = PULSE_HI;
                    timer_n = TW'(CLK_DIV - 1);
                end
            end
            PULSE_HI: begin
                if (timer == '0) begin
                    state_n = PULSE_LO;
                    timer_n = TW'(CLK_DIV - 1);
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            PULSE_LO: begin
                if (timer == '0) begin
                    state_n   = SAMPLE;
                    bit_idx_n = bit_idx + 1'b1;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            DONE: begin
`ifdef DEBOUNCE_EN
                prev_n = shift;
                if (shift == prev_raw) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                    if (shift != controller_data) int_n = 1'b1;
                end
`else
                data_n  = shift;
                valid_n = 1'b1;
                if (shift != controller_data) int_n = 1'b1;
`endif
                state_n    = IDLE;
                idle_cnt_n = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Pad strobes are registered copies of the upcoming state.
        latch_n = (state_n == LATCH);
        pulse_n = (state_n == PULSE_HI);
    end

endmodule
